// File: rtl/csr_access_unit.sv
// csr_access_unit: initiator for the 8-entry machine-mode CSR register file.
// Takes one CSR/system operation at a time, reads the target CSR, then issues
// a write or trap strobe. It returns the rd value and any PC redirect
// through a valid/ready handshake.
module csr_access_unit #(
  parameter int         DATA_WIDTH = 32,
  parameter logic [2:0] MTVEC_IDX  = 3'h1,
  parameter logic [2:0] MEPC_IDX   = 3'h2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [11:0]           in_csr,
  input  logic [DATA_WIDTH-1:0] in_src,
  input  logic [31:0]           in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rd,
  output logic                  out_redirect,
  output logic [31:0]           out_npc,
  output logic                  out_illegal,
  output logic [2:0]            csr_addr,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic [2:0]            csr_waddr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  csr_wen,
  output logic                  csr_ecall,
  output logic [31:0]           csr_pc
);

  localparam logic [2:0] OP_RW    = 3'd0;
  localparam logic [2:0] OP_RS    = 3'd1;
  localparam logic [2:0] OP_RC    = 3'd2;
  localparam logic [2:0] OP_ECALL = 3'd3;
  localparam logic [2:0] OP_MRET  = 3'd4;

  typedef enum logic [1:0] {IDLE, READ, EXEC, RESP} state_t;

  state_t                state;
  logic [2:0]            op_q;
  logic [DATA_WIDTH-1:0] src_q;
  logic [31:0]           pc_q;
  logic                  illegal_q;
  logic [DATA_WIDTH-1:0] old_q;

  // Architectural CSR number -> {mapped, file index}.
  function automatic logic [3:0] map_csr(input logic [11:0] num);
    case (num)
      12'h300: map_csr = {1'b1, 3'd4};
      12'h305: map_csr = {1'b1, 3'd1};
      12'h341: map_csr = {1'b1, 3'd2};
      12'h342: map_csr = {1'b1, 3'd3};
      12'hF11: map_csr = {1'b1, 3'd5};
      12'hF12: map_csr = {1'b1, 3'd6};
      default: map_csr = 4'b0000;
    endcase
  endfunction

  logic [3:0]            map_in;
  logic                  ro_in;
  logic                  writes_in;
  logic                  illegal_in;
  logic [2:0]            rd_idx_in;
  logic                  writes_c;
  logic [DATA_WIDTH-1:0] wdata_c;

  // Decode the incoming request and precompute the write-back value from the read data.
  always_comb begin
    map_in     = map_csr(in_csr);
    ro_in      = map_in[2] & (map_in[1] ^ map_in[0]);   // index 5 or 6
    writes_in  = (in_op == OP_RW) || (in_src != '0);
    illegal_in = 1'b0;
    rd_idx_in  = map_in[2:0];
    if (in_op > OP_MRET)
      illegal_in = 1'b1;
    else if (in_op == OP_ECALL)
      rd_idx_in = MTVEC_IDX;
    else if (in_op == OP_MRET)
      rd_idx_in = MEPC_IDX;
    else if (!map_in[3] || (ro_in && writes_in))
      illegal_in = 1'b1;

    // Set/clear with a zero mask is a pure read: no write strobe.
    writes_c = !illegal_q &&
               ((op_q == OP_RW) ||
                (((op_q == OP_RS) || (op_q == OP_RC)) && (src_q != '0)));
    case (op_q)
      OP_RS:   wdata_c = csr_rdata | src_q;
      OP_RC:   wdata_c = csr_rdata & ~src_q;
      default: wdata_c = src_q;
    endcase
  end

  // Request sequencer: IDLE -> READ -> EXEC -> RESP with every output registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      op_q         <= '0;
      src_q        <= '0;
      pc_q         <= '0;
      illegal_q    <= 1'b0;
      old_q        <= '0;
      out_valid    <= 1'b0;
      out_rd       <= '0;
      out_redirect <= 1'b0;
      out_npc      <= '0;
      out_illegal  <= 1'b0;
      csr_addr     <= '0;
      csr_waddr    <= '0;
      csr_wdata    <= '0;
      csr_wen      <= 1'b0;
      csr_ecall    <= 1'b0;
      csr_pc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_q      <= in_op;
            src_q     <= in_src;
            pc_q      <= in_pc;
            illegal_q <= illegal_in;
            csr_addr  <= rd_idx_in;
            in_ready  <= 1'b0;
            state     <= READ;
          end
        end
        READ: begin
          // The strobe for EXEC is launched here so it is high for exactly that cycle.
          old_q <= csr_rdata;
          if (writes_c) begin
            csr_wen   <= 1'b1;
            csr_waddr <= csr_addr;
            csr_wdata <= wdata_c;
          end
          if (op_q == OP_ECALL) begin
            csr_ecall <= 1'b1;
            csr_pc    <= pc_q;
          end
          state <= EXEC;
        end
        EXEC: begin
          csr_wen      <= 1'b0;
          csr_waddr    <= '0;
          csr_wdata    <= '0;
          csr_ecall    <= 1'b0;
          csr_pc       <= '0;
          out_valid    <= 1'b1;
          out_illegal  <= illegal_q;
          out_rd       <= (!illegal_q && (op_q <= OP_RC)) ? old_q : '0;
          out_redirect <= (op_q == OP_ECALL) || (op_q == OP_MRET);
          out_npc      <= ((op_q == OP_ECALL) || (op_q == OP_MRET)) ? 32'(old_q) : 32'd0;
          state        <= RESP;
        end
        default: begin
          if (out_ready) begin
            out_valid    <= 1'b0;
            out_rd       <= '0;
            out_redirect <= 1'b0;
            out_npc      <= '0;
            out_illegal  <= 1'b0;
            in_ready     <= 1'b1;
            state        <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: an 8-entry CSR file model answers the read port
// and applies write/trap strobes. A reference model predicts each operation
// from the CSR map and file contents captured when the request is issued.
module tb_csr_access_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [11:0] in_csr = '0;
  logic [31:0] in_src = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rd;
  logic        out_redirect;
  logic [31:0] out_npc;
  logic        out_illegal;
  logic [2:0]  csr_addr;
  logic [31:0] csr_rdata;
  logic [2:0]  csr_waddr;
  logic [31:0] csr_wdata;
  logic        csr_wen;
  logic        csr_ecall;
  logic [31:0] csr_pc;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] file [8];

  csr_access_unit #(.DATA_WIDTH(32), .MTVEC_IDX(3'h1), .MEPC_IDX(3'h2)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_csr(in_csr),
    .in_src(in_src), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_redirect(out_redirect), .out_npc(out_npc), .out_illegal(out_illegal),
    .csr_addr(csr_addr), .csr_rdata(csr_rdata), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .csr_wen(csr_wen), .csr_ecall(csr_ecall), .csr_pc(csr_pc)
  );

  always #5 clock = ~clock;

  // CSR register file model.
  assign csr_rdata = file[csr_addr];
  always @(posedge clock) begin
    if (csr_wen) file[csr_waddr] <= csr_wdata;
    else if (csr_ecall) begin
      file[2] <= csr_pc;
      file[3] <= 32'd1;
    end
  end

  typedef struct {
    logic [2:0]  addr;
    logic        wen;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic        ecall;
    logic [31:0] cpc;
    logic [31:0] rd;
    logic        redirect;
    logic [31:0] npc;
    logic        illegal;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: behaviour derived from the CSR map and the current file contents.
  function automatic exp_t model(input logic [2:0] op, input logic [11:0] csr,
                                 input logic [31:0] src, input logic [31:0] pc);
    exp_t e;
    int idx;
    logic [31:0] old;
    logic will_write;
    e = '{default: '0};
    case (csr)
      12'h300: idx = 4;
      12'h305: idx = 1;
      12'h341: idx = 2;
      12'h342: idx = 3;
      12'hF11: idx = 5;
      12'hF12: idx = 6;
      default: idx = -1;
    endcase
    if (op == 3) begin
      e.addr = 3'd1; e.ecall = 1'b1; e.cpc = pc; e.redirect = 1'b1; e.npc = file[1];
    end else if (op == 4) begin
      e.addr = 3'd2; e.redirect = 1'b1; e.npc = file[2];
    end else if (op > 4 || idx < 0) begin
      e.illegal = 1'b1;
    end else begin
      old = file[idx];
      will_write = (op == 0) || (src != 0);
      if ((idx == 5 || idx == 6) && will_write) e.illegal = 1'b1;
      else begin
        e.addr = 3'(idx);
        e.rd = old;
        if (will_write) begin
          e.wen = 1'b1;
          e.waddr = 3'(idx);
          e.wdata = (op == 0) ? src : (op == 1) ? (old | src) : (old & ~src);
        end
      end
    end
    return e;
  endfunction

  task automatic check_result(input exp_t e, input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    check({tag, ".out_rd"}, out_rd, e.rd);
    check({tag, ".out_redirect"}, 32'(out_redirect), 32'(e.redirect));
    check({tag, ".out_npc"}, out_npc, e.npc);
    check({tag, ".out_illegal"}, 32'(out_illegal), 32'(e.illegal));
    check({tag, ".idle_wen"}, 32'(csr_wen), 32'd0);
    check({tag, ".idle_ecall"}, 32'(csr_ecall), 32'd0);
  endtask

  // One full operation: request, READ, EXEC strobe check, RESP with hold cycles, handshake.
  task automatic do_op(input logic [2:0] op, input logic [11:0] csr, input logic [31:0] src,
                       input logic [31:0] pc, input int hold, input string tag);
    exp_t e;
    e = model(op, csr, src, pc);
    @(negedge clock);
    check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = op; in_csr = csr; in_src = src; in_pc = pc;
    @(posedge clock); #1;
    in_valid = 1'b0; in_op = $urandom; in_csr = $urandom; in_src = $urandom; in_pc = $urandom;
    // READ
    check({tag, ".read_wen"}, 32'(csr_wen), 32'd0);
    check({tag, ".read_ecall"}, 32'(csr_ecall), 32'd0);
    check({tag, ".read_valid"}, 32'(out_valid), 32'd0);
    if (!e.illegal) check({tag, ".csr_addr"}, 32'(csr_addr), 32'(e.addr));
    @(posedge clock); #1;
    // EXEC
    check({tag, ".csr_wen"}, 32'(csr_wen), 32'(e.wen));
    check({tag, ".csr_waddr"}, 32'(csr_waddr), 32'(e.waddr));
    check({tag, ".csr_wdata"}, csr_wdata, e.wdata);
    check({tag, ".csr_ecall"}, 32'(csr_ecall), 32'(e.ecall));
    check({tag, ".csr_pc"}, csr_pc, e.cpc);
    check({tag, ".exec_valid"}, 32'(out_valid), 32'd0);
    @(posedge clock); #1;
    // RESP
    check_result(e, tag);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      check_result(e, {tag, ".hold"});
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check({tag, ".post_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".post_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] csr_tab [8];
    logic [2:0]  op;
    logic [11:0] csr;
    logic [31:0] src;
    csr_tab = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hF11, 12'hF12, 12'h7C0, 12'h000};
    file = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h1800, 32'h12345678, 32'd22050499, 32'h0};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.csr_wen", 32'(csr_wen), 32'd0);
    check("rst.csr_ecall", 32'(csr_ecall), 32'd0);
    check("rst.out_rd", out_rd, 32'd0);
    check("rst.csr_addr", 32'(csr_addr), 32'd0);
    @(negedge clock); reset = 1'b1;

    // Directed sequence
    do_op(3'd0, 12'h305, 32'h80000100, 32'h0, 0, "csrrw_mtvec");
    do_op(3'd1, 12'h342, 32'h4, 32'h0, 0, "csrrs_mcause");
    do_op(3'd0, 12'h342, 32'h1, 32'h0, 0, "csrrw_mcause_restore");
    do_op(3'd1, 12'h342, 32'h0, 32'h0, 0, "csrrs_zero");
    do_op(3'd3, 12'h000, 32'h0, 32'h80000040, 0, "ecall");
    do_op(3'd4, 12'h000, 32'h0, 32'h0, 0, "mret");
    do_op(3'd0, 12'hF11, 32'h55, 32'h0, 0, "rw_readonly");
    do_op(3'd2, 12'h7C0, 32'h1, 32'h0, 0, "rc_unmapped");
    do_op(3'd6, 12'h305, 32'h1, 32'h0, 0, "bad_op");
    do_op(3'd1, 12'hF12, 32'h0, 32'h0, 0, "rs_mimpid");
    do_op(3'd2, 12'h300, 32'h800, 32'h0, 5, "backpressure");

    // Reset during EXEC of a CSRRW
    @(negedge clock);
    in_valid = 1'b1; in_op = 3'd0; in_csr = 12'h341; in_src = 32'hDEADBEEF; in_pc = 32'h0;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    check("abort.exec_wen", 32'(csr_wen), 32'd1);
    reset = 1'b0;
    #1;
    check("abort.csr_wen", 32'(csr_wen), 32'd0);
    check("abort.in_ready", 32'(in_ready), 32'd1);
    check("abort.out_valid", 32'(out_valid), 32'd0);
    check("abort.mepc_kept", file[2], 32'h80000040);
    @(negedge clock); reset = 1'b1;
    do_op(3'd1, 12'h341, 32'h0, 32'h0, 0, "after_abort");

    // Randomized operations
    for (int n = 0; n < 200; n++) begin
      op  = 3'($urandom_range(0, 7));
      csr = csr_tab[$urandom_range(0, 7)];
      if (csr == 12'h000) csr = 12'($urandom);
      src = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      do_op(op, csr, src, $urandom, $urandom_range(0, 3), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
